// File: rtl/boot_loader.sv
// Boot loader: receives a framed (length, payload, checksum) word stream, writes the
// payload into the instruction ROM and holds the CPU in reset until the image verifies.
module boot_loader #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 16384,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [14:0] rom_addr,
    output logic [15:0] rom_data,
    output logic        rom_we,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [14:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [14:0]   BASE  = 15'(BASE_ADDR);
    localparam logic [16:0]   MAXW  = 17'(MAX_WORDS);

    state_t        r_state, w_state_nxt;
    logic [14:0]   r_count, w_count_nxt;
    logic [14:0]   r_len, w_len_nxt;
    logic [15:0]   r_sum, w_sum_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          w_xfer;
    logic          w_expire;
    logic          w_we_nxt;
    logic [14:0]   w_addr_nxt;
    logic [15:0]   w_data_nxt;

    // in_ready is only ever high in LEN/LOAD/CSUM, so this is the handshake qualifier
    assign w_xfer   = in_valid & in_ready;
    assign w_expire = (TIMEOUT != 0) && busy && !w_xfer && (r_timer == TLAST);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_len_nxt   = r_len;
        w_sum_nxt   = r_sum;
        w_timer_nxt = r_timer;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = rom_addr;
        w_data_nxt  = rom_data;

        if (w_xfer) begin
            w_timer_nxt = '0;
        end else if (busy && (TIMEOUT != 0)) begin
            w_timer_nxt = r_timer + 1'b1;
        end

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_LEN;
                    w_count_nxt = '0;
                    w_sum_nxt   = '0;
                    w_timer_nxt = '0;
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    if ((in_data == 16'd0) || ({1'b0, in_data} > MAXW)) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_len_nxt   = in_data[14:0];
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = BASE + r_count;
                    w_data_nxt  = in_data;
                    w_sum_nxt   = r_sum + in_data;
                    w_count_nxt = r_count + 15'd1;
                    if ((r_count + 15'd1) == r_len) begin
                        w_state_nxt = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    w_state_nxt = (in_data == r_sum) ? S_DONE : S_ERR;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // a transfer in the same cycle takes priority, which w_expire already encodes
        if (w_expire) begin
            w_state_nxt = S_ERR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_len    <= '0;
            r_sum    <= '0;
            r_timer  <= '0;
            rom_we   <= 1'b0;
            rom_addr <= '0;
            rom_data <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_len    <= w_len_nxt;
            r_sum    <= w_sum_nxt;
            r_timer  <= w_timer_nxt;
            rom_we   <= w_we_nxt;
            rom_addr <= w_addr_nxt;
            rom_data <= w_data_nxt;
            in_ready <= (w_state_nxt == S_LEN) || (w_state_nxt == S_LOAD) || (w_state_nxt == S_CSUM);
            busy     <= (w_state_nxt == S_LEN) || (w_state_nxt == S_LOAD) || (w_state_nxt == S_CSUM);
            done     <= (w_state_nxt == S_DONE);
            error    <= (w_state_nxt == S_ERR);
            cpu_hold <= (w_state_nxt != S_DONE);
        end
    end

    assign words_loaded = r_count;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (base 0 and base 0x7FFE, timeout 8) share one
// stimulus stream; a stream-level model predicts every output each cycle.
module tb_boot_loader;

    localparam int TMO   = 8;
    localparam int BASEB = 32766;
    localparam int P_IDLE = 0, P_LEN = 1, P_LOAD = 2, P_CSUM = 3, P_DONE = 4, P_ERR = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;

    logic        a_ready, a_we, a_hold, a_busy, a_done, a_err;
    logic [14:0] a_addr, a_wl;
    logic [15:0] a_data;
    logic        b_ready, b_we, b_hold, b_busy, b_done, b_err;
    logic [14:0] b_addr, b_wl;
    logic [15:0] b_data;

    always #5 clk = ~clk;

    boot_loader #(.BASE_ADDR(0), .MAX_WORDS(16384), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_ready), .rom_addr(a_addr), .rom_data(a_data), .rom_we(a_we),
        .cpu_hold(a_hold), .busy(a_busy), .done(a_done), .error(a_err), .words_loaded(a_wl)
    );

    boot_loader #(.BASE_ADDR(BASEB), .MAX_WORDS(16384), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_ready), .rom_addr(b_addr), .rom_data(b_data), .rom_we(b_we),
        .cpu_hold(b_hold), .busy(b_busy), .done(b_done), .error(b_err), .words_loaded(b_wl)
    );

    int n_vec  = 0;
    int n_miss = 0;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Stream-level model: phase of the frame, payload received so far, idle cycles.
    int          m_phase = P_IDLE;
    int          m_len   = 0;
    int          m_idle  = 0;
    int          m_k     = 0;
    int          m_was;
    int          m_sum;
    bit          m_xfer;
    bit          m_we    = 1'b0;
    logic [15:0] m_wdata = 16'd0;
    logic [15:0] m_words[$];

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_phase = P_IDLE;
                m_words.delete();
                m_idle  = 0;
                m_we    = 1'b0;
            end else begin
                m_was  = m_phase;
                m_xfer = in_valid && (m_was == P_LEN || m_was == P_LOAD || m_was == P_CSUM);
                m_we   = 1'b0;
                if ((m_was == P_IDLE || m_was == P_DONE || m_was == P_ERR) && start) begin
                    m_phase = P_LEN;
                    m_words.delete();
                    m_idle  = 0;
                end else if (m_xfer) begin
                    m_idle = 0;
                    if (m_was == P_LEN) begin
                        if (in_data == 16'd0 || int'(in_data) > 16384) m_phase = P_ERR;
                        else begin
                            m_len   = int'(in_data);
                            m_phase = P_LOAD;
                        end
                    end else if (m_was == P_LOAD) begin
                        m_we    = 1'b1;
                        m_k     = m_words.size();
                        m_wdata = in_data;
                        m_words.push_back(in_data);
                        if (m_words.size() == m_len) m_phase = P_CSUM;
                    end else begin
                        m_sum = 0;
                        foreach (m_words[i]) m_sum += int'(m_words[i]);
                        m_phase = ((m_sum % 65536) == int'(in_data)) ? P_DONE : P_ERR;
                    end
                end else if (m_was == P_LEN || m_was == P_LOAD || m_was == P_CSUM) begin
                    m_idle++;
                    if (m_idle >= TMO) m_phase = P_ERR;
                end
            end
        end
    end

    function automatic void cmp_dut(string t, logic rdy, logic bsy, logic dn, logic er,
                                    logic hld, logic we, logic [14:0] addr, logic [15:0] data,
                                    logic [14:0] wl, int base);
        int eb;
        eb = (m_phase == P_LEN || m_phase == P_LOAD || m_phase == P_CSUM) ? 1 : 0;
        chk({t, ".in_ready"}, int'(rdy), eb);
        chk({t, ".busy"}, int'(bsy), eb);
        chk({t, ".done"}, int'(dn), (m_phase == P_DONE) ? 1 : 0);
        chk({t, ".error"}, int'(er), (m_phase == P_ERR) ? 1 : 0);
        chk({t, ".cpu_hold"}, int'(hld), (m_phase == P_DONE) ? 0 : 1);
        chk({t, ".words_loaded"}, int'(wl), m_words.size());
        chk({t, ".rom_we"}, int'(we), int'(m_we));
        if (m_we) begin
            chk({t, ".rom_addr"}, int'(addr), (base + m_k) % 32768);
            chk({t, ".rom_data"}, int'(data), int'(m_wdata));
        end
    endfunction

    always @(negedge clk) begin
        cmp_dut("a", a_ready, a_busy, a_done, a_err, a_hold, a_we, a_addr, a_data, a_wl, 0);
        cmp_dut("b", b_ready, b_busy, b_done, b_err, b_hold, b_we, b_addr, b_data, b_wl, BASEB);
    end

    // Observed ROM write log per instance, with cycle stamps.
    int          cyc = 0;
    int          la_addr[$], la_data[$], la_cyc[$];
    int          lb_addr[$], lb_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_we) begin
            la_addr.push_back(int'(a_addr));
            la_data.push_back(int'(a_data));
            la_cyc.push_back(cyc);
        end
        if (b_we) begin
            lb_addr.push_back(int'(b_addr));
            lb_data.push_back(int'(b_data));
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] w);
        bit rdy;
        int n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        forever begin
            rdy = a_ready;
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 20) begin
                chk("send.ready_wait", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic gap();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    int base_n;

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.cpu_hold", int'(a_hold), 1);
        chk("rst.in_ready", int'(a_ready), 0);
        chk("rst.rom_addr", int'(a_addr), 0);
        @(negedge clk);
        reset = 1'b1;

        // in_valid while idle must not transfer
        in_valid = 1'b1; in_data = 16'h0055;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle.no_write", la_addr.size(), 0);

        // nominal load
        pulse_start();
        send(16'd3); send(16'h1111); send(16'h2222); send(16'h3333); send(16'h6666);
        in_valid = 1'b0;
        #1;
        chk("nom.done", int'(a_done), 1);
        chk("nom.cpu_hold", int'(a_hold), 0);
        chk("nom.error", int'(a_err), 0);
        chk("nom.busy", int'(a_busy), 0);
        chk("nom.words_loaded", int'(a_wl), 3);
        chk("nom.nwrites", la_addr.size(), 3);
        if (la_addr.size() == 3) begin
            chk("nom.addr0", la_addr[0], 0);
            chk("nom.addr2", la_addr[2], 2);
            chk("nom.data1", la_data[1], 16'h2222);
            chk("nom.consecutive", la_cyc[2] - la_cyc[0], 2);
        end

        // start from DONE re-arms hold; continue with a bad checksum
        @(negedge clk);
        pulse_start();
        #1;
        chk("restart.cpu_hold", int'(a_hold), 1);
        chk("restart.done", int'(a_done), 0);
        chk("restart.busy", int'(a_busy), 1);
        base_n = la_addr.size();
        send(16'd3); send(16'h1111); send(16'h2222); send(16'h3333); send(16'h6667);
        in_valid = 1'b0;
        #1;
        chk("badck.error", int'(a_err), 1);
        chk("badck.cpu_hold", int'(a_hold), 1);
        chk("badck.done", int'(a_done), 0);
        chk("badck.nwrites", la_addr.size() - base_n, 3);
        @(negedge clk);
        pulse_start();
        send(16'd3); send(16'h1111); send(16'h2222); send(16'h3333); send(16'h6666);
        in_valid = 1'b0;
        #1;
        chk("recover.done", int'(a_done), 1);
        chk("recover.error", int'(a_err), 0);

        // illegal lengths
        @(negedge clk);
        base_n = la_addr.size();
        pulse_start();
        send(16'd0);
        in_valid = 1'b0;
        #1;
        chk("len0.error", int'(a_err), 1);
        @(negedge clk);
        pulse_start();
        send(16'd16385);
        in_valid = 1'b0;
        #1;
        chk("lenmax.error", int'(a_err), 1);
        repeat (2) @(negedge clk);
        chk("badlen.no_write", la_addr.size() - base_n, 0);

        // timeout after two payload words
        pulse_start();
        send(16'd4); send(16'h0101); send(16'h0202);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        chk("tmo.not_yet", int'(a_err), 0);
        @(negedge clk);
        #1;
        chk("tmo.error", int'(a_err), 1);
        chk("tmo.words_loaded", int'(a_wl), 2);

        // stalls, ignored start while busy, address wrap on instance b
        @(negedge clk);
        pulse_start();
        send(16'd3);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(16'h000A); gap();
        send(16'h000B); gap();
        send(16'h000C); gap();
        send(16'h0021);
        in_valid = 1'b0;
        #1;
        chk("wrap.done", int'(b_done), 1);
        if (lb_addr.size() >= 3) begin
            chk("wrap.addr0", lb_addr[lb_addr.size() - 3], 16'h7FFE);
            chk("wrap.addr1", lb_addr[lb_addr.size() - 2], 16'h7FFF);
            chk("wrap.addr2", lb_addr[lb_addr.size() - 1], 0);
            chk("wrap.data2", lb_data[lb_data.size() - 1], 16'h000C);
        end else begin
            chk("wrap.nwrites", lb_addr.size(), 3);
        end

        // asynchronous reset mid-load with a write pending
        @(negedge clk);
        pulse_start();
        send(16'd3); send(16'h1111);
        #2 reset = 1'b0;
        #1;
        chk("arst.rom_we", int'(a_we), 0);
        chk("arst.cpu_hold", int'(a_hold), 1);
        chk("arst.in_ready", int'(a_ready), 0);
        chk("arst.words_loaded", int'(a_wl), 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("arst.idle_busy", int'(a_busy), 0);
        @(negedge clk);
        pulse_start();
        #1;
        chk("arst.start_busy", int'(a_busy), 1);
        send(16'd3); send(16'h1111); send(16'h2222); send(16'h3333); send(16'h6666);
        in_valid = 1'b0;
        #1;
        chk("arst.reload_done", int'(a_done), 1);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want finish");
        $fatal(1);
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sequences the instruction ROM (mem16k) at power-up or on request.
- Accepts a framed word stream (length, payload, checksum) over a valid/ready handshake and writes the payload into ROM starting at BASE_ADDR.
- Holds the CPU in reset until the image is loaded and its checksum verifies.
- Sits between the external program source and the ROM write port; drives the CPU reset/hold.

Parameters:
- BASE_ADDR, 0, first ROM word address written (15-bit).
- MAX_WORDS, 16384, largest accepted payload length.
- TIMEOUT, 1024, idle cycles allowed between accepted words while loading; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load.
- in_data  input  16  stream word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- rom_addr  output  15  ROM write address.
- rom_data  output  16  ROM write data.
- rom_we  output  1  ROM write enable, one cycle per payload word.
- cpu_hold  output  1  CPU reset request, high while the image is not valid.
- busy  output  1  high in LEN, LOAD or CSUM.
- done  output  1  image loaded and verified.
- error  output  1  load failed.
- words_loaded  output  15  payload words written so far in the current load.

Behaviour:
- Reset value of every output:
  - rom_addr=0, rom_data=0, words_loaded=0.
  - rom_we=0, in_ready=0, busy=0, done=0, error=0.
  - cpu_hold=1.
  - State is IDLE.
- Transfer rule: a word transfers on a rising edge where in_valid & in_ready are both high.
- in_ready is a registered function of state: 1 in LEN, LOAD and CSUM; 0 otherwise.
- States:
  - IDLE: start -> LEN; clear count, sum and timer.
  - LEN: the transferred word is N.
    - N==0 or N>MAX_WORDS -> ERR.
    - Otherwise latch N and go to LOAD.
  - LOAD: each transferred word adds into a 16-bit sum (mod 2^16) and increments words_loaded.
    - When words_loaded reaches N after the transfer -> CSUM.
  - CSUM: the transferred word is compared with the sum.
    - Equal -> DONE.
    - Not equal -> ERR.
  - DONE: done=1, cpu_hold=0. start -> LEN with done=0 and cpu_hold=1 from the next cycle.
  - ERR: error=1, cpu_hold=1. start -> LEN with error cleared.
- ROM write timing, per LOAD transfer of word k (0-based):
  - The next cycle presents rom_we=1, rom_addr=(BASE_ADDR+k) mod 2^15 and rom_data=word.
  - Latency is exactly 1 cycle.
  - rom_we is 0 in every other cycle.
- Address wrap: the address wraps modulo 2^15; no error is raised for wrap.
- Back-to-back transfers every cycle are supported; this produces consecutive rom_we pulses.
- busy=1 exactly in LEN, LOAD and CSUM.
- Timeout:
  - The idle counter resets on every transfer and on entry to LEN.
  - It increments each busy cycle without a transfer.
  - Reaching TIMEOUT -> ERR; the count does not increment further.
  - With TIMEOUT=0 the timeout is disabled.
- start while busy is ignored.
- in_valid outside busy states is ignored; no transfer occurs.
- The LEN and CSUM words never cause ROM writes.
- An asynchronous reset assertion mid-load returns to IDLE with all outputs at reset values immediately. A ROM write pending that cycle is dropped. Partial ROM contents are undefined, and cpu_hold stays high.
- A transfer and a timeout expiry in the same cycle: the transfer wins.

Test Plan:
- Nominal load:
  - Stimulus: reset release, start, then words 3, 0x1111, 0x2222, 0x3333, 0x6666, each valid back-to-back.
  - Required: rom_we pulses at addresses 0, 1, 2 with those data on consecutive cycles; words_loaded=3.
  - Then done=1, cpu_hold=0, error=0, busy=0.
- Bad checksum:
  - Stimulus: same stream with checksum 0x6667.
  - Required: three ROM writes occur, then error=1, cpu_hold=1, done=0.
  - A subsequent start plus the correct stream ends with done=1 and error=0.
- Illegal length:
  - Stimulus: length word 0; separately, length MAX_WORDS+1.
  - Required: ERR the cycle after the transfer; no rom_we pulses.
- Timeout (TIMEOUT=8):
  - Stimulus: length 4, two payload words, then in_valid held low.
  - Required: error=1 after 8 idle cycles; words_loaded=2.
- Stalls and wrap (BASE_ADDR=0x7FFE):
  - Stimulus: length 3 with payload 0xA, 0xB, 0xC and in_valid toggling every other cycle.
  - Required: writes land at 0x7FFE, 0x7FFF, 0x0000; checksum 0x0021 gives done.
- Reset mid-load:
  - Stimulus: assert reset during LOAD after one payload word.
  - Required: outputs return to reset values immediately (cpu_hold=1, in_ready=0, rom_we=0), and state is IDLE after release.
  - start during DONE begins a new load and raises cpu_hold.
